// File: rtl/sweep_pairer_if.sv
// sweep_pairer_if: pulse input stream and paired-record output stream of the sweep pairer
interface sweep_pairer_if;
    logic        io_pulseIn_valid;
    logic        io_pulseIn_ready;
    logic [16:0] io_pulseIn_payload_offset;
    logic [5:0]  io_pulseIn_payload_npoly;
    logic [23:0] io_pulseIn_payload_pulse_timestamp;
    logic [15:0] io_pulseIn_payload_pulse_width;
    logic [16:0] io_pulseIn_payload_beamWord;
    logic [1:0]  io_pulseIn_payload_id;
    logic        io_pairOut_valid;
    logic        io_pairOut_ready;
    logic [4:0]  io_pairOut_payload_npoly;
    logic [1:0]  io_pairOut_payload_id;
    logic [23:0] io_pairOut_payload_sweep1;
    logic [23:0] io_pairOut_payload_sweep2;

    modport master (
        output io_pulseIn_valid, io_pulseIn_payload_offset, io_pulseIn_payload_npoly,
               io_pulseIn_payload_pulse_timestamp, io_pulseIn_payload_pulse_width,
               io_pulseIn_payload_beamWord, io_pulseIn_payload_id, io_pairOut_ready,
        input  io_pulseIn_ready, io_pairOut_valid, io_pairOut_payload_npoly,
               io_pairOut_payload_id, io_pairOut_payload_sweep1, io_pairOut_payload_sweep2
    );

    modport slave (
        input  io_pulseIn_valid, io_pulseIn_payload_offset, io_pulseIn_payload_npoly,
               io_pulseIn_payload_pulse_timestamp, io_pulseIn_payload_pulse_width,
               io_pulseIn_payload_beamWord, io_pulseIn_payload_id, io_pairOut_ready,
        output io_pulseIn_ready, io_pairOut_valid, io_pairOut_payload_npoly,
               io_pairOut_payload_id, io_pairOut_payload_sweep1, io_pairOut_payload_sweep2
    );
endinterface

// File: rtl/sweep_pairer.sv
// sweep_pairer: pairs two back-projected sweeps of one rotor revolution; SWEEP_PAIRER_STATS_EN adds drop/orphan counters
module sweep_pairer #(
    parameter int          BIT_SHIFT = 3,
    parameter logic [23:0] MAX_GAP   = 24'd20000
) (
    input  logic               Slow_clk,
    input  logic               Slow_resetn,
    sweep_pairer_if.slave      bus,
    output logic [15:0]        io_dropCount,
    output logic [15:0]        io_orphanCount
);
    typedef enum logic [1:0] {IDLE, HOLD, EMIT} state_t;

    state_t      state_q;
    logic [5:0]  p_npoly_q;
    logic [1:0]  p_id_q;
    logic [23:0] p_t_q;
    logic [23:0] age_q;
    logic        valid_q;
    logic [4:0]  o_npoly_q;
    logic [1:0]  o_id_q;
    logic [23:0] o_s1_q;
    logic [23:0] o_s2_q;

    logic        acc;
    logic        ident;
    logic        hit;
    logic        expire;
    logic [23:0] off_sh;
    logic [23:0] t;
    logic [23:0] delta;
    logic        unused;

    // Ready is gated by reset so nothing is taken while the block is being cleared.
    assign bus.io_pulseIn_ready = Slow_resetn && (state_q != EMIT);
    assign acc    = bus.io_pulseIn_valid && bus.io_pulseIn_ready;
    assign ident  = bus.io_pulseIn_payload_npoly != 6'h3F;
    assign off_sh = {7'd0, bus.io_pulseIn_payload_offset} << BIT_SHIFT;
    assign t      = bus.io_pulseIn_payload_pulse_timestamp - off_sh;
    assign delta  = t - p_t_q;
    assign hit    = (bus.io_pulseIn_payload_npoly == p_npoly_q) && (bus.io_pulseIn_payload_id == p_id_q)
                    && (delta != 24'd0) && (delta <= MAX_GAP);
    assign expire = (age_q + 24'd1) == MAX_GAP;
    assign unused = ^{bus.io_pulseIn_payload_pulse_width, bus.io_pulseIn_payload_beamWord};

    assign bus.io_pairOut_valid         = valid_q;
    assign bus.io_pairOut_payload_npoly = o_npoly_q;
    assign bus.io_pairOut_payload_id    = o_id_q;
    assign bus.io_pairOut_payload_sweep1 = o_s1_q;
    assign bus.io_pairOut_payload_sweep2 = o_s2_q;

    // Pairing FSM: capture a pending sweep, pair or replace it, age it out, then hold the record until taken.
    always_ff @(posedge Slow_clk) begin
        if (!Slow_resetn) begin
            state_q   <= IDLE;
            p_npoly_q <= '0;
            p_id_q    <= '0;
            p_t_q     <= '0;
            age_q     <= '0;
            valid_q   <= 1'b0;
            o_npoly_q <= '0;
            o_id_q    <= '0;
            o_s1_q    <= '0;
            o_s2_q    <= '0;
        end else begin
            case (state_q)
                IDLE: if (acc && ident) begin
                    p_npoly_q <= bus.io_pulseIn_payload_npoly;
                    p_id_q    <= bus.io_pulseIn_payload_id;
                    p_t_q     <= t;
                    age_q     <= '0;
                    state_q   <= HOLD;
                end
                HOLD: if (acc && ident) begin
                    if (hit) begin
                        o_npoly_q <= p_npoly_q[4:0];
                        o_id_q    <= p_id_q;
                        o_s1_q    <= p_t_q;
                        o_s2_q    <= t;
                        valid_q   <= 1'b1;
                        state_q   <= EMIT;
                    end else begin
                        p_npoly_q <= bus.io_pulseIn_payload_npoly;
                        p_id_q    <= bus.io_pulseIn_payload_id;
                        p_t_q     <= t;
                        age_q     <= '0;
                    end
                end else if (expire) begin
                    age_q   <= '0;
                    state_q <= IDLE;
                end else begin
                    age_q <= age_q + 24'd1;
                end
                EMIT: if (bus.io_pairOut_ready) begin
                    valid_q <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

`ifdef SWEEP_PAIRER_STATS_EN
    logic [15:0] drop_q, drop_d, orphan_q, orphan_d;
    logic        drop_ev, orphan_ev;

    // Saturating next values for the discard statistics.
    always_comb begin
        drop_ev   = acc && !ident;
        orphan_ev = (state_q == HOLD) && ((acc && ident) ? !hit : expire);
        drop_d    = drop_q + {15'd0, drop_ev && !(&drop_q)};
        orphan_d  = orphan_q + {15'd0, orphan_ev && !(&orphan_q)};
    end

    // Statistics registers.
    always_ff @(posedge Slow_clk) begin
        if (!Slow_resetn) begin
            drop_q   <= '0;
            orphan_q <= '0;
        end else begin
            drop_q   <= drop_d;
            orphan_q <= orphan_d;
        end
    end

    assign io_dropCount   = drop_q;
    assign io_orphanCount = orphan_q;
`else
    assign io_dropCount   = 16'h0000;
    assign io_orphanCount = 16'h0000;
`endif
endmodule

// File: tb/tb_sweep_pairer.sv
// tb_sweep_pairer: scoreboard bench for sweep_pairer pairing, wrap, timeout, backpressure and reset
module tb_sweep_pairer;
    localparam logic [23:0] MAX_GAP = 24'd20000;
`ifdef SWEEP_PAIRER_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic [15:0] drop_cnt, orphan_cnt;
    int          n_chk = 0;
    int          n_fail = 0;
    int          exp_drop = 0;
    int          exp_orphan = 0;
    logic [54:0] sb_q[$];

    sweep_pairer_if bus();

    sweep_pairer #(.BIT_SHIFT(3), .MAX_GAP(MAX_GAP)) dut (
        .Slow_clk(clk),
        .Slow_resetn(resetn),
        .bus(bus),
        .io_dropCount(drop_cnt),
        .io_orphanCount(orphan_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [23:0] ct(input logic [23:0] ts, input logic [16:0] off);
        return ts - {4'd0, off, 3'd0};
    endfunction

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [5:0] np, input logic [1:0] id, input logic [23:0] ts, input logic [16:0] off);
        bit ok = 1'b0;
        bus.io_pulseIn_valid = 1'b1;
        bus.io_pulseIn_payload_npoly = np;
        bus.io_pulseIn_payload_id = id;
        bus.io_pulseIn_payload_pulse_timestamp = ts;
        bus.io_pulseIn_payload_offset = off;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk);
            ok = bus.io_pulseIn_ready;
        end
        chk("send_ready", {63'd0, ok}, 64'd1);
        @(posedge clk);
        #1;
        bus.io_pulseIn_valid = 1'b0;
    endtask

    task automatic push(input logic [4:0] np, input logic [1:0] id, input logic [23:0] s1, input logic [23:0] s2);
        sb_q.push_back({np, id, s1, s2});
    endtask

    task automatic chk_cnt(input string tag);
        chk({tag, "_drop"}, {48'd0, drop_cnt}, STATS ? 64'(exp_drop) : 64'd0);
        chk({tag, "_orph"}, {48'd0, orphan_cnt}, STATS ? 64'(exp_orphan) : 64'd0);
    endtask

    // Output monitor: every accepted record must match the oldest expected one.
    always @(negedge clk) begin
        if (bus.io_pairOut_valid && bus.io_pairOut_ready) begin
            if (sb_q.size() == 0) chk("unexpected_rec", 64'd1, 64'd0);
            else chk("rec", {9'd0, bus.io_pairOut_payload_npoly, bus.io_pairOut_payload_id,
                             bus.io_pairOut_payload_sweep1, bus.io_pairOut_payload_sweep2},
                     {9'd0, sb_q.pop_front()});
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

    initial begin
        bus.io_pulseIn_valid = 1'b0;
        bus.io_pulseIn_payload_offset = '0;
        bus.io_pulseIn_payload_npoly = '0;
        bus.io_pulseIn_payload_pulse_timestamp = '0;
        bus.io_pulseIn_payload_pulse_width = '0;
        bus.io_pulseIn_payload_beamWord = '0;
        bus.io_pulseIn_payload_id = '0;
        bus.io_pairOut_ready = 1'b1;
        idle(2);
        @(negedge clk);
        chk("rst_in_ready", {63'd0, bus.io_pulseIn_ready}, 64'd0);
        chk("rst_valid", {63'd0, bus.io_pairOut_valid}, 64'd0);
        chk("rst_payload", {bus.io_pairOut_payload_npoly, bus.io_pairOut_payload_id,
                            bus.io_pairOut_payload_sweep1, bus.io_pairOut_payload_sweep2}, 64'd0);
        chk_cnt("rst");
        resetn = 1'b1;
        idle(1);
        @(negedge clk);
        chk("idle_in_ready", {63'd0, bus.io_pulseIn_ready}, 64'd1);

        // basic pair with offset back-projection
        idle(1);
        send(6'd3, 2'd1, 24'd1000, 17'd10);
        push(5'd3, 2'd1, 24'd920, 24'd4840);
        send(6'd3, 2'd1, 24'd5000, 17'd20);
        @(negedge clk);
        chk("pair_latency", {63'd0, bus.io_pairOut_valid}, 64'd1);
        chk("emit_in_ready", {63'd0, bus.io_pulseIn_ready}, 64'd0);
        idle(2);

        // corrected time wraps below zero
        send(6'd5, 2'd2, 24'h000010, 17'd4);
        push(5'd5, 2'd2, 24'hFFFFF0, 24'd100);
        send(6'd5, 2'd2, 24'd100, 17'd0);
        idle(2);

        // polynomial mismatch replaces the pending pulse
        send(6'd3, 2'd0, 24'd2000, 17'd0);
        send(6'd4, 2'd0, 24'd3000, 17'd0);
        exp_orphan++;
        push(5'd4, 2'd0, 24'd3000, 24'd4000);
        send(6'd4, 2'd0, 24'd4000, 17'd0);
        idle(2);
        chk_cnt("mismatch");

        // unidentified pulse between halves is dropped
        send(6'd7, 2'd3, 24'd6000, 17'd0);
        send(6'h3F, 2'd3, 24'd6500, 17'd0);
        exp_drop++;
        push(5'd7, 2'd3, 24'd6000, 24'd7000);
        send(6'd7, 2'd3, 24'd7000, 17'd0);
        idle(2);
        chk_cnt("unident");

        // second pulse in the timeout cycle still pairs
        send(6'd9, 2'd1, 24'd10000, 17'd0);
        idle(int'(MAX_GAP) - 1);
        push(5'd9, 2'd1, 24'd10000, 24'd10500);
        send(6'd9, 2'd1, 24'd10500, 17'd0);
        idle(2);
        chk_cnt("to_edge");

        // pending pulse expires exactly MAX_GAP cycles after capture
        send(6'd9, 2'd1, 24'd20000, 17'd0);
        idle(int'(MAX_GAP) - 1);
        chk_cnt("to_before");
        idle(1);
        exp_orphan++;
        chk_cnt("to_after");
        send(6'd9, 2'd1, 24'd20100, 17'd0);
        @(negedge clk);
        chk("to_nopair", {63'd0, bus.io_pairOut_valid}, 64'd0);
        idle(1);
        push(5'd9, 2'd1, 24'd20100, 24'd20200);
        send(6'd9, 2'd1, 24'd20200, 17'd0);
        idle(2);

        // backpressure holds the record stable and stalls input
        bus.io_pairOut_ready = 1'b0;
        send(6'd2, 2'd2, 24'd30000, 17'd0);
        push(5'd2, 2'd2, 24'd30000, ct(24'd31000, 17'd8));
        send(6'd2, 2'd2, 24'd31000, 17'd8);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("bp_valid", {63'd0, bus.io_pairOut_valid}, 64'd1);
            chk("bp_sweep2", {40'd0, bus.io_pairOut_payload_sweep2}, 64'd30936);
            chk("bp_in_ready", {63'd0, bus.io_pulseIn_ready}, 64'd0);
        end
        @(posedge clk);
        #1;
        bus.io_pairOut_ready = 1'b1;
        idle(2);

        // reset while a record is waiting
        bus.io_pairOut_ready = 1'b0;
        send(6'd1, 2'd0, 24'd40000, 17'd0);
        send(6'd1, 2'd0, 24'd40100, 17'd0);
        @(negedge clk);
        chk("emit_valid", {63'd0, bus.io_pairOut_valid}, 64'd1);
        resetn = 1'b0;
        @(posedge clk);
        #1;
        exp_drop = 0;
        exp_orphan = 0;
        @(negedge clk);
        chk("rst_emit_valid", {63'd0, bus.io_pairOut_valid}, 64'd0);
        chk("rst_emit_s1", {40'd0, bus.io_pairOut_payload_sweep1}, 64'd0);
        chk("rst_emit_in_ready", {63'd0, bus.io_pulseIn_ready}, 64'd0);
        chk_cnt("rst_emit");
        resetn = 1'b1;
        @(posedge clk);
        #1;
        bus.io_pairOut_ready = 1'b1;
        send(6'd1, 2'd0, 24'd50000, 17'd0);
        push(5'd1, 2'd0, 24'd50000, 24'd50010);
        send(6'd1, 2'd0, 24'd50010, 17'd0);
        idle(3);

        chk("sb_empty", 64'(sb_q.size()), 64'd0);
        chk_cnt("final");
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
